// File: rtl/fir_sample_feeder.sv
// Purpose : buffers upstream samples and releases one per FIR frame, held stable for the frame.
// Latency : first sample 1 clk after the FIFO reaches PRIME_LEVEL in PRIME, then every FRAME_LEN clks.
// Backpr. : s_ready drops when the FIFO is full (registered level, no bypass); a tick on empty outputs 0.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   enable         1 = run frames, 0 = return to IDLE (FIFO and sample_out kept)
//   s_valid/s_data upstream sample handshake; s_ready = FIFO not full
//   sample_out     sample presented to the filter, updated only on a frame tick
//   frame_start    1-clk pulse in the first cycle of a new sample_out
//   frame_cnt      position in frame, 0..FRAME_LEN-1
//   fifo_level     FIFO occupancy, 0..FIFO_DEPTH
//   underrun       sticky flag: a frame tick found the FIFO empty (cleared by rst only)
module fir_sample_feeder #(
  parameter int DATA_BIT_NUM  = 16,
  parameter int FRAME_LEN     = 65,
  parameter int COUNT_BIT_NUM = 7,
  parameter int FIFO_DEPTH    = 16,
  parameter int PRIME_LEVEL   = 4,
  localparam int PTR_W        = $clog2(FIFO_DEPTH),
  localparam int LVL_W        = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     s_valid,
  input  logic [DATA_BIT_NUM-1:0]  s_data,
  output logic                     s_ready,
  output logic [DATA_BIT_NUM-1:0]  sample_out,
  output logic                     frame_start,
  output logic [COUNT_BIT_NUM-1:0] frame_cnt,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [COUNT_BIT_NUM-1:0] CNT_LAST  = COUNT_BIT_NUM'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0]         LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]         LVL_PRIME = LVL_W'(PRIME_LEVEL);

  state_t                   state_q, state_d;
  logic [COUNT_BIT_NUM-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]         level_q;
  logic [DATA_BIT_NUM-1:0]  sample_q;
  logic                     frame_start_q;
  logic                     underrun_q;
  logic [DATA_BIT_NUM-1:0]  mem_q [FIFO_DEPTH];

  logic tick;
  logic push;
  logic pop;
  logic fifo_empty;

  assign s_ready    = (level_q != LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign push       = s_valid & s_ready;
  // A tick always happens on schedule; it only pops when something is there.
  assign pop        = tick & ~fifo_empty;

  // Next-state / frame counter / tick decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PRIME;
          cnt_d   = '0;
        end
        PRIME: begin
          cnt_d = '0;
          if (level_q >= LVL_PRIME) begin
            state_d = RUN;
            tick    = 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
          end else begin
            cnt_d = cnt_q + COUNT_BIT_NUM'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      sample_q      <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_start_q <= tick;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        sample_q <= mem_q[rd_ptr_q];
      end else if (tick) begin
        // Empty at a tick: feed the filter silence and remember it.
        sample_q   <= '0;
        underrun_q <= 1'b1;
      end

      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage has no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign sample_out  = sample_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = cnt_q;
  assign fifo_level  = level_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] sample_out;
  logic        frame_start;
  logic [6:0]  frame_cnt;
  logic [4:0]  fifo_level;
  logic        underrun;

  int checks;
  int errors;

  fir_sample_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .sample_out  (sample_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .fifo_level  (fifo_level),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    step(2);
    rst = 1'b0;
  endtask

  // Push values base, base+1, ... one per clock; inputs idle afterwards.
  task automatic push_seq(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = base + 16'(i);
      step(1);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b1; s_data = 16'h00AA;
    step(2);
    s_valid = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (sample_out !== 16'h0) begin errors++; $display("FAIL reset_sample got %h exp 0000", sample_out); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s_ready); end
    checks++; if (frame_start !== 1'b0 || frame_cnt !== 7'd0) begin errors++; $display("FAIL reset_frame got fs=%b cnt=%0d exp fs=0 cnt=0", frame_start, frame_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_priming();
    reset_dut();
    enable = 1'b1;
    push_seq(16'h0001, 4);
    checks++; if (fifo_level !== 5'd4 || frame_start !== 1'b0) begin errors++; $display("FAIL prime_pre got lvl=%0d fs=%b exp lvl=4 fs=0", fifo_level, frame_start); end
    step(1);
    checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0001) begin errors++; $display("FAIL prime_tick1 got fs=%b smp=%h exp fs=1 smp=0001", frame_start, sample_out); end
    checks++; if (fifo_level !== 5'd3 || frame_cnt !== 7'd0) begin errors++; $display("FAIL prime_tick1_lvl got lvl=%0d cnt=%0d exp lvl=3 cnt=0", fifo_level, frame_cnt); end
    for (int c = 1; c <= 64; c++) begin
      step(1);
      checks++; if (frame_start !== 1'b0 || sample_out !== 16'h0001 || frame_cnt !== 7'(c)) begin errors++; $display("FAIL prime_hold got fs=%b smp=%h cnt=%0d exp fs=0 smp=0001 cnt=%0d", frame_start, sample_out, frame_cnt, c); end
    end
    step(1);
    checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0002 || frame_cnt !== 7'd0) begin errors++; $display("FAIL prime_tick2 got fs=%b smp=%h cnt=%0d exp fs=1 smp=0002 cnt=0", frame_start, sample_out, frame_cnt); end
    step(65);
    checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0003) begin errors++; $display("FAIL prime_tick3 got fs=%b smp=%h exp fs=1 smp=0003", frame_start, sample_out); end
  endtask

  task automatic test_full();
    reset_dut();
    push_seq(16'h0100, 16);
    checks++; if (fifo_level !== 5'd16 || s_ready !== 1'b0) begin errors++; $display("FAIL full_level got lvl=%0d rdy=%b exp lvl=16 rdy=0", fifo_level, s_ready); end
    s_valid = 1'b1; s_data = 16'hDEAD;
    step(1);
    s_valid = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_blocked got lvl=%0d exp 16", fifo_level); end
    enable = 1'b1;
    step(2);
    checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0100 || fifo_level !== 5'd15) begin errors++; $display("FAIL full_first got fs=%b smp=%h lvl=%0d exp fs=1 smp=0100 lvl=15", frame_start, sample_out, fifo_level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", s_ready); end
    for (int k = 1; k < 16; k++) begin
      step(65);
      checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL full_drain got fs=%b smp=%h exp fs=1 smp=%h", frame_start, sample_out, 16'h0100 + 16'(k)); end
    end
    step(65);
    checks++; if (sample_out !== 16'h0 || underrun !== 1'b1) begin errors++; $display("FAIL full_no17th got smp=%h urun=%b exp smp=0000 urun=1", sample_out, underrun); end
  endtask

  task automatic test_underrun();
    reset_dut();
    enable = 1'b1;
    push_seq(16'h0011, 4);
    step(1);
    checks++; if (sample_out !== 16'h0011) begin errors++; $display("FAIL urun_s1 got %h exp 0011", sample_out); end
    for (int k = 1; k < 4; k++) begin
      step(65);
      checks++; if (sample_out !== 16'h0011 + 16'(k) || underrun !== 1'b0) begin errors++; $display("FAIL urun_seq got smp=%h urun=%b exp smp=%h urun=0", sample_out, underrun, 16'h0011 + 16'(k)); end
    end
    step(65);
    checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0 || underrun !== 1'b1) begin errors++; $display("FAIL urun_empty got fs=%b smp=%h urun=%b exp fs=1 smp=0000 urun=1", frame_start, sample_out, underrun); end
    s_valid = 1'b1; s_data = 16'h0055;
    step(1);
    s_valid = 1'b0;
    checks++; if (underrun !== 1'b1 || fifo_level !== 5'd1) begin errors++; $display("FAIL urun_sticky got urun=%b lvl=%0d exp urun=1 lvl=1", underrun, fifo_level); end
  endtask

  task automatic test_push_pop();
    reset_dut();
    enable = 1'b1;
    push_seq(16'h0021, 4);
    step(1);
    checks++; if (fifo_level !== 5'd3 || sample_out !== 16'h0021) begin errors++; $display("FAIL pp_setup got lvl=%0d smp=%h exp lvl=3 smp=0021", fifo_level, sample_out); end
    step(64);
    s_valid = 1'b1; s_data = 16'h0030;
    step(1);
    s_valid = 1'b0;
    checks++; if (frame_start !== 1'b1 || sample_out !== 16'h0022 || fifo_level !== 5'd3) begin errors++; $display("FAIL pp_tick got fs=%b smp=%h lvl=%0d exp fs=1 smp=0022 lvl=3", frame_start, sample_out, fifo_level); end
    step(65);
    checks++; if (sample_out !== 16'h0023) begin errors++; $display("FAIL pp_next1 got %h exp 0023", sample_out); end
    step(65);
    checks++; if (sample_out !== 16'h0024) begin errors++; $display("FAIL pp_next2 got %h exp 0024", sample_out); end
    step(65);
    checks++; if (sample_out !== 16'h0030 || fifo_level !== 5'd0) begin errors++; $display("FAIL pp_pushed got smp=%h lvl=%0d exp smp=0030 lvl=0", sample_out, fifo_level); end
  endtask

  task automatic test_mid_frame();
    reset_dut();
    enable = 1'b1;
    push_seq(16'h0041, 4);
    step(31);
    checks++; if (frame_cnt !== 7'd30) begin errors++; $display("FAIL mid_cnt got %0d exp 30", frame_cnt); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (fifo_level !== 5'd0 || sample_out !== 16'h0 || frame_cnt !== 7'd0 || frame_start !== 1'b0 || underrun !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst got lvl=%0d smp=%h cnt=%0d fs=%b urun=%b rdy=%b exp 0 0000 0 0 0 1", fifo_level, sample_out, frame_cnt, frame_start, underrun, s_ready);
    end
    // rst dropped above with enable still high: the FIFO is empty so this re-primes.
    push_seq(16'h0041, 4);
    step(31);
    checks++; if (frame_cnt !== 7'd30 || sample_out !== 16'h0041) begin errors++; $display("FAIL mid_cnt2 got cnt=%0d smp=%h exp cnt=30 smp=0041", frame_cnt, sample_out); end
    enable = 1'b0;
    step(1);
    checks++; if (frame_cnt !== 7'd0 || sample_out !== 16'h0041 || fifo_level !== 5'd3) begin errors++; $display("FAIL mid_dis got cnt=%0d smp=%h lvl=%0d exp cnt=0 smp=0041 lvl=3", frame_cnt, sample_out, fifo_level); end
    for (int c = 0; c < 70; c++) begin
      step(1);
      checks++; if (frame_cnt !== 7'd0 || frame_start !== 1'b0 || sample_out !== 16'h0041) begin errors++; $display("FAIL mid_idle got cnt=%0d fs=%b smp=%h exp cnt=0 fs=0 smp=0041", frame_cnt, frame_start, sample_out); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    test_reset();
    test_priming();
    test_full();
    test_underrun();
    test_push_pop();
    test_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
